// File: rtl/bcd_conv_sched.sv
// Binary-to-BCD conversion engine shared by two requesters.
// Round-robin grant, serial double-dabble (one bit per clock), valid/ready result port.
module bcd_conv_sched #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Digits = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_valid_i,
  input  logic [Width-1:0]      req_data0_i,
  input  logic [Width-1:0]      req_data1_i,
  output logic [1:0]            req_ack_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_id_o,
  output logic [4*Digits-1:0]   out_bcd_o,
  output logic                  busy_o
);

  localparam int unsigned BcdW = 4 * Digits;
  localparam int unsigned CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  op_q, op_d;
  logic [BcdW-1:0]   dig_q, dig_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        ack_q, ack_d;
  logic              out_valid_q, out_valid_d;
  logic              out_id_q, out_id_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;

  logic                  grant;
  logic [BcdW-1:0]       dig_adj;
  logic [BcdW+Width-1:0] shifted;
  logic [BcdW-1:0]       dig_step;
  logic [Width-1:0]      op_step;

  // Single requester wins outright; on contention the one not served last time wins.
  always_comb begin
    grant = req_valid_i[1];
    if (&req_valid_i) begin
      grant = ~last_grant_q;
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift operand MSB into digit 0.
  always_comb begin
    dig_adj = dig_q;
    for (int unsigned i = 0; i < Digits; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
    shifted  = {dig_adj, op_q} << 1;
    dig_step = shifted[BcdW+Width-1:Width];
    op_step  = shifted[Width-1:0];
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dig_d        = dig_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ack_d        = 2'b00;
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_bcd_d    = out_bcd_q;

    unique case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          op_d         = grant ? req_data1_i : req_data0_i;
          dig_d        = '0;
          cnt_d        = '0;
          last_grant_d = grant;
          ack_d        = grant ? 2'b10 : 2'b01;
          state_d      = StShift;
        end
      end
      StShift: begin
        dig_d = dig_step;
        op_d  = op_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Width - 1)) begin
          out_bcd_d   = dig_step;
          out_id_d    = last_grant_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= '0;
      dig_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      ack_q        <= 2'b00;
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_bcd_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_bcd_q    <= out_bcd_d;
    end
  end

  assign req_ack_o   = ack_q;
  assign out_valid_o = out_valid_q;
  assign out_id_o    = out_id_q;
  assign out_bcd_o   = out_bcd_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for bcd_conv_sched (Width=8, Digits=3).
module tb_bcd_conv_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [7:0]  req_data0_i;
  logic [7:0]  req_data1_i;
  logic [1:0]  req_ack_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_id_o;
  logic [11:0] out_bcd_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_conv_sched #(
    .Width  (8),
    .Digits (3)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data0_i (req_data0_i),
    .req_data1_i (req_data1_i),
    .req_ack_o   (req_ack_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_id_o    (out_id_o),
    .out_bcd_o   (out_bcd_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference built from division, independent of shift-add-3.
  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One transaction with out_ready held high; checks ack, latency, result, return to idle.
  task automatic do_conv(input logic r, input logic [7:0] d, input logic [11:0] exp);
    int lat;
    @(negedge clk_i);
    if (r) req_data1_i = d; else req_data0_i = d;
    req_valid_i = r ? 2'b10 : 2'b01;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("ack", req_ack_o, r ? 2'b10 : 2'b01);
    req_valid_i = 2'b00;
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq("latency", lat, 8);
    check_eq("bcd", out_bcd_o, exp);
    check_eq("id", out_id_o, r);
    @(negedge clk_i);
    check_eq("idle_after", {out_valid_o, busy_o}, 2'b00);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_outs", {req_ack_o, out_valid_o, out_id_o, out_bcd_o, busy_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [11:0] res_bcd [3];
    logic        res_id  [3];
    logic [1:0]  acks    [3];
    int          n_res, n_ack, busy_cnt;

    rst_ni      = 1'b0;
    req_valid_i = 2'b00;
    req_data0_i = 8'd0;
    req_data1_i = 8'd0;
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("reset_state", {req_ack_o, out_valid_o, out_id_o, out_bcd_o, busy_o}, 0);
    rst_ni = 1'b1;

    // 1: 255 from requester 0
    do_conv(1'b0, 8'd255, 12'h255);

    // 2: zero from requester 1; busy spans 8 SHIFT cycles plus one DONE cycle
    @(negedge clk_i);
    req_data1_i = 8'd0;
    req_valid_i = 2'b10;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      req_valid_i = 2'b00;
      if (busy_o) busy_cnt++;
    end
    check_eq("busy_cycles", busy_cnt, 9);
    check_eq("zero_bcd", out_bcd_o, 12'h000);
    check_eq("zero_id", out_id_o, 1'b1);

    // 3: both held high after reset -> alternating grants 0,1,0
    apply_reset();
    req_data0_i = 8'd123;
    req_data1_i = 8'd45;
    req_valid_i = 2'b11;
    out_ready_i = 1'b1;
    n_res = 0;
    n_ack = 0;
    for (int i = 0; i < 45 && n_res < 3; i++) begin
      @(negedge clk_i);
      if (req_ack_o != 2'b00 && n_ack < 3) begin
        acks[n_ack] = req_ack_o;
        n_ack++;
      end
      if (out_valid_o) begin
        res_bcd[n_res] = out_bcd_o;
        res_id[n_res]  = out_id_o;
        n_res++;
      end
    end
    req_valid_i = 2'b00;
    check_eq("rr_count", n_res, 3);
    check_eq("rr_acks", n_ack, 3);
    if (n_res == 3 && n_ack == 3) begin
      check_eq("rr0_bcd", res_bcd[0], 12'h123);
      check_eq("rr0_id", res_id[0], 1'b0);
      check_eq("rr1_bcd", res_bcd[1], 12'h045);
      check_eq("rr1_id", res_id[1], 1'b1);
      check_eq("rr2_bcd", res_bcd[2], 12'h123);
      check_eq("rr2_id", res_id[2], 1'b0);
      check_eq("rr_ack_seq", {acks[0], acks[1], acks[2]}, 6'b01_10_01);
    end
    repeat (12) @(negedge clk_i);

    // 4: backpressure in DONE; new requests must be ignored
    @(negedge clk_i);
    req_data0_i = 8'd99;
    req_valid_i = 2'b01;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 2'b00;
    for (int i = 0; i < 30 && !out_valid_o; i++) @(negedge clk_i);
    check_eq("bp_valid", out_valid_o, 1'b1);
    req_valid_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq("bp_hold", {out_valid_o, out_bcd_o, out_id_o, req_ack_o}, {1'b1, 12'h099, 1'b0, 2'b00});
    end
    req_valid_i = 2'b00;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("bp_release", {out_valid_o, busy_o}, 2'b00);
    check_eq("bp_keep_bcd", out_bcd_o, 12'h099);

    // 5: reset during the 4th SHIFT cycle of 200
    @(negedge clk_i);
    req_data0_i = 8'd200;
    req_valid_i = 2'b01;
    @(negedge clk_i);
    req_valid_i = 2'b00;
    repeat (3) @(negedge clk_i);
    check_eq("pre_abort_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_eq("abort_outs", {req_ack_o, out_valid_o, out_id_o, out_bcd_o, busy_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      check_eq("abort_quiet", {out_valid_o, req_ack_o}, 3'b000);
    end
    do_conv(1'b0, 8'd7, 12'h007);

    // 6: full sweep on both requesters
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 256; v++) begin
        do_conv(r[0], v[7:0], ref_bcd(v));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
